sel_arb_2: RTL and testbench
============================

# sel_arb_2

Two-requester round-robin arbiter that drives the select bit `x` of the downstream 2:1 selector (input `a` when `x`=0, input `b` when `x`=1). It grants one of two sources at a time, holds the grant for a bounded burst of accepted beats, and rotates fairly under contention. It sits directly upstream of the selector's control input; grant outputs go back to the sources.

## Interface
- `MAX_BURST`, default 4: beats (acks) per grant before forced rotation; legal range 1..2^`CW`-1.
- `CW`, default 3: width of the burst counter.

Ports (clock and reset first):
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst_n`  in  1: asynchronous reset, active-low.
- `req_a`  in  1: source A requests the selector path.
- `req_b`  in  1: source B requests the selector path.
- `ack`  in  1: consumer accepted one beat through the selector this cycle.
- `x`  out  1: select for the 2:1 selector; 0 = A, 1 = B.
- `gnt_a`  out  1: A owns the path.
- `gnt_b`  out  1: B owns the path.
- `busy`  out  1: `gnt_a | gnt_b`.
- `lock`  in  1: present only with `SEL_ARB_LOCK_EN` (see Configuration).

## Operation
- All outputs are registered. There is no combinational path from inputs to outputs.
- States: `IDLE`, `GNT_A`, `GNT_B`. Internal state: `last` pointer (last granted side) and burst counter `cnt` (`CW` bits).
- Reset values: state `IDLE`, `x`=0, `gnt_a`=0, `gnt_b`=0, `busy`=0, `cnt`=0, `last`=B. With `last`=B, the first contention goes to A.
- `IDLE`:
  - Only `req_a` asserted -> `GNT_A`.
  - Only `req_b` asserted -> `GNT_B`.
  - Both asserted -> grant the side opposite `last`.
  - Neither asserted -> stay in `IDLE`.
  - `x` holds its previous value in `IDLE`; it never toggles without a grant.
- `GNT_A` (`GNT_B` is symmetric):
  - `x`=0 and `gnt_a`=1.
  - Each cycle with `ack`=1 increments `cnt`.
  - Release when `req_a`=0. Go to `GNT_B` if `req_b`=1, otherwise to `IDLE`.
  - Forced rotation: when `ack`=1 and `cnt`==`MAX_BURST`-1, the burst ends. If `req_b`=1, go to `GNT_B`. Otherwise stay in `GNT_A` with `cnt` cleared to 0.
  - On every grant change (including entry from `IDLE`): `cnt` clears to 0, `last` updates to the new side, and `x` updates in the same cycle as the grant.
- `gnt_a` and `gnt_b` are never both 1. `x` always equals the granted side while `busy`=1.
- `ack` while `busy`=0 is ignored.
- If `ack`=1 and the requester drops in the same cycle, the beat is counted and the grant is released.
- Simultaneous burst end and requester drop: release rules apply. The result is the same next state either way.
- If `rst_n` asserts mid-grant, all state returns to reset values immediately (asynchronously). After `rst_n` deasserts, arbitration restarts from `IDLE`.

## Timing
- Grant latency: a request sampled at edge n produces `gnt_*`/`x` valid after edge n; there is no request-to-grant combinational path.
- Handover: with the other side requesting, the last accepted beat at edge n is followed by the new grant and `x` after edge n. There are no dead cycles.
- Release to `IDLE`: the grant drops after the edge that samples the request low.
- Burst: at most `MAX_BURST` acks per grant under contention.
- Fairness: under continuous requests from both sides, grants alternate A, B, A, B, and each grant holds for `MAX_BURST` acks.

## Configuration
- Macro `SEL_ARB_LOCK_EN`.
- Defined: adds the input `lock`. While `lock`=1 in a grant state, forced rotation is suppressed. `cnt` saturates at `MAX_BURST`-1. Release still occurs on requester drop. When `lock` falls, the next ack with `cnt`==`MAX_BURST`-1 rotates.
- Undefined: the `lock` port does not exist and the burst limit is always enforced.

## Test plan
- Reset: `rst_n`=0 with random inputs -> `x`=0, `gnt_a`=`gnt_b`=`busy`=0. Assert mid-grant -> outputs clear without waiting for a clock edge.
- Single requester: `req_a`=1 for 10 cycles with `ack`=1 every cycle, `MAX_BURST`=4 -> `gnt_a` stays 1 throughout (`cnt` wraps), `x`=0, `gnt_b` never asserts.
- Contention from reset: `req_a`=`req_b`=1 with `ack`=1 every cycle -> A granted for 4 acks, then B for 4, then A. `x` toggles exactly at handover with no idle cycles.
- Early release: `GNT_B` with `req_b` dropping after 2 acks and `req_a`=1 -> `gnt_a`=1, `x`=0 on the next edge. The new grant's `cnt` is 0.
- Ack while idle: both requests 0, `ack` pulsed -> no state change. A following single `req_b` -> `gnt_b` on the next edge.
- `SEL_ARB_LOCK_EN`: contention with `lock`=1 held for 10 acks -> A keeps the grant. Drop `lock` -> rotation to B on the next ack.

Source files
------------

// File: rtl/sel_arb_2.sv
// sel_arb_2: two-requester round-robin arbiter driving the select bit of a 2:1 selector.
// Optional build macro SEL_ARB_LOCK_EN adds a 'lock' input that suppresses forced rotation.
//
// state | meaning
// IDLE  | no grant; x holds its last value
// GNT_A | source A owns the path, x=0
// GNT_B | source B owns the path, x=1
module sel_arb_2 #(
   parameter int MAX_BURST = 4,
   parameter int CW        = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_a,
   input  logic req_b,
   input  logic ack,
`ifdef SEL_ARB_LOCK_EN
   input  logic lock,
`endif
   output logic x,
   output logic gnt_a,
   output logic gnt_b,
   output logic busy
);

   typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            last_q, last_d;   // 1 = B granted last
   logic            x_d;
   logic            lock_hold;
   logic            own_req, oth_req;

`ifdef SEL_ARB_LOCK_EN
   assign lock_hold = lock;
`else
   assign lock_hold = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         last_q  <= 1'b1;
         x       <= 1'b0;
         gnt_a   <= 1'b0;
         gnt_b   <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         x       <= x_d;
         gnt_a   <= (state_d == GNT_A);
         gnt_b   <= (state_d == GNT_B);
         busy    <= (state_d != IDLE);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      x_d     = x;
      own_req = (state_q == GNT_B) ? req_b : req_a;
      oth_req = (state_q == GNT_B) ? req_a : req_b;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (req_a && (!req_b || last_q))
               state_d = GNT_A;
            else if (req_b)
               state_d = GNT_B;
         end
         GNT_A, GNT_B: begin
            if (!own_req) begin
               state_d = oth_req ? ((state_q == GNT_A) ? GNT_B : GNT_A) : IDLE;
            end else if (ack) begin
               // At the burst limit: rotate if the other side waits, else restart the burst.
               // With lock held the counter saturates instead.
               if (cnt_q == CNT_LAST) begin
                  if (!lock_hold) begin
                     cnt_d = '0;
                     if (oth_req)
                        state_d = (state_q == GNT_A) ? GNT_B : GNT_A;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d != state_q)
         cnt_d = '0;
      if (state_d != IDLE) begin
         last_d = (state_d == GNT_B);
         x_d    = (state_d == GNT_B);
      end
   end

endmodule

// File: tb/tb_sel_arb_2.sv
// Testbench for sel_arb_2: vector table, hand-written corner sequences and random
// stimulus against a behavioural model of the arbitration rules.
module tb_sel_arb_2;

   localparam int MAX_BURST = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req_a = 1'b0, req_b = 1'b0, ack = 1'b0, lock = 1'b0;
   logic x, gnt_a, gnt_b, busy;

   int n_tests = 0;
   int n_fail  = 0;

   // model: owner 0 = none, 1 = A, 2 = B; last 1 = A, 2 = B
   int m_own, m_cnt, m_last;
   logic m_x;

   always #5 clk = ~clk;

   sel_arb_2 #(.MAX_BURST(MAX_BURST), .CW(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req_a (req_a),
      .req_b (req_b),
      .ack   (ack),
`ifdef SEL_ARB_LOCK_EN
      .lock  (lock),
`endif
      .x     (x),
      .gnt_a (gnt_a),
      .gnt_b (gnt_b),
      .busy  (busy)
   );

   typedef struct {
      logic       ra;
      logic       rb;
      logic       ak;
      logic [3:0] exp;   // {gnt_a, gnt_b, busy, x}
   } vec_t;

   vec_t vecs[17];

   function automatic logic [3:0] outs();
      return {gnt_a, gnt_b, busy, x};
   endfunction

   function automatic logic [3:0] m_outs();
      return {m_own == 1, m_own == 2, m_own != 0, m_x};
   endfunction

   task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got {gnt_a,gnt_b,busy,x}=%b expected %b", name, $time, got, exp);
      end
   endtask

   task automatic m_reset();
      m_own = 0; m_cnt = 0; m_last = 2; m_x = 1'b0;
   endtask

   task automatic m_grant(input int side);
      m_own = side; m_cnt = 0; m_last = side; m_x = (side == 2);
   endtask

   task automatic m_update(input logic ra, input logic rb, input logic ak, input logic lk);
      logic mine, other;
      if (m_own == 0) begin
         if (ra && rb)  m_grant(m_last == 2 ? 1 : 2);
         else if (ra)   m_grant(1);
         else if (rb)   m_grant(2);
      end else begin
         mine  = (m_own == 1) ? ra : rb;
         other = (m_own == 1) ? rb : ra;
         if (!mine) begin
            if (other) m_grant(3 - m_own);
            else begin m_own = 0; m_cnt = 0; end
         end else if (ak) begin
            if (m_cnt + 1 < MAX_BURST) m_cnt = m_cnt + 1;
            else if (!lk) begin
               if (other) m_grant(3 - m_own);
               else m_cnt = 0;
            end
         end
      end
   endtask

   // Drive inputs away from the edge, advance one clock, sample 1 ns after the edge.
   task automatic step(input logic ra, input logic rb, input logic ak, input logic lk);
      req_a = ra; req_b = rb; ack = ak; lock = lk;
`ifdef SEL_ARB_LOCK_EN
      m_update(ra, rb, ak, lk);
`else
      m_update(ra, rb, ak, 1'b0);
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      m_reset();
      req_a = 1'b0; req_b = 1'b0; ack = 1'b0; lock = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{1'b0, 1'b0, 1'b1, 4'b0000};  // ack while idle
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 4'b0111};
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 4'b0111};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 4'b0111};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 4'b1010};  // B drops after 2 acks
      vecs[5]  = '{1'b1, 1'b1, 1'b1, 4'b1010};
      vecs[6]  = '{1'b1, 1'b1, 1'b1, 4'b1010};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 4'b1010};
      vecs[8]  = '{1'b1, 1'b1, 1'b1, 4'b0111};  // 4th ack rotates
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'b0001};  // x holds in idle
      vecs[10] = '{1'b1, 1'b1, 1'b0, 4'b1010};  // last was B -> A
      vecs[11] = '{1'b1, 1'b0, 1'b1, 4'b1010};
      vecs[12] = '{1'b1, 1'b0, 1'b1, 4'b1010};
      vecs[13] = '{1'b1, 1'b0, 1'b1, 4'b1010};
      vecs[14] = '{1'b1, 1'b0, 1'b1, 4'b1010};
      vecs[15] = '{1'b1, 1'b0, 1'b1, 4'b1010};
      vecs[16] = '{1'b0, 1'b0, 1'b1, 4'b0000};

      m_reset();
      // reset held with random inputs
      for (int i = 0; i < 4; i++) begin
         req_a = 1'($urandom); req_b = 1'($urandom); ack = 1'($urandom); lock = 1'($urandom);
         @(posedge clk); #1;
         check("reset_hold", outs(), 4'b0000);
      end
      req_a = 1'b0; req_b = 1'b0; ack = 1'b0; lock = 1'b0;
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         step(vecs[i].ra, vecs[i].rb, vecs[i].ak, 1'b0);
         check($sformatf("vec%0d", i), outs(), vecs[i].exp);
      end

      // contention from reset: A x4, B x4, A x4, handing over without idle cycles
      do_reset();
      for (int i = 1; i <= 12; i++) begin
         step(1'b1, 1'b1, 1'b1, 1'b0);
         check($sformatf("contend%0d", i), outs(),
               (((i - 1) / MAX_BURST) % 2 == 0) ? 4'b1010 : 4'b0111);
      end

      // asynchronous reset mid-grant
      #2 rst_n = 1'b0;
      #1 check("async_rst", outs(), 4'b0000);
      m_reset();
      req_a = 1'b0; req_b = 1'b0; ack = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check("post_rst_b", outs(), 4'b0111);
      step(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef SEL_ARB_LOCK_EN
      do_reset();
      step(1'b1, 1'b1, 1'b0, 1'b1);
      check("lock_grant", outs(), 4'b1010);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b1, 1'b1, 1'b1);
         check($sformatf("lock_hold%0d", i), outs(), 4'b1010);
      end
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check("lock_release", outs(), 4'b0111);
`endif

      // random stimulus against the model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
              1'($urandom), ($urandom_range(0, 4) == 0));
         check("random", outs(), m_outs());
         if (gnt_a && gnt_b) check("onehot", 4'b1100, 4'b0000);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
